// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types for the hazard controller and its neighbours.
// Holds the ctrl_state encoding, the register-index width and the stall/flush bundle layout.
package hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_stall;
        logic exmm_stall;
        logic ifid_flush;
        logic idex_flush;
        logic exmm_flush;
        logic mmwb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE   = pipe_ctrl_t'(8'b0000_0000);
    localparam pipe_ctrl_t CTRL_MEM    = pipe_ctrl_t'(8'b1111_0001);
    localparam pipe_ctrl_t CTRL_MD     = pipe_ctrl_t'(8'b1110_0010);
    localparam pipe_ctrl_t CTRL_REDIR  = pipe_ctrl_t'(8'b0000_1100);
    localparam pipe_ctrl_t CTRL_LDUSE  = pipe_ctrl_t'(8'b1100_0100);

    // x0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic src_hit(
        input logic [REG_IDX_W-1:0] rd,
        input logic                 used,
        input logic [REG_IDX_W-1:0] rs
    );
        return used && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_wait_timer.sv
// MEM-wait watchdog: counts enabled cycles since the last clear and flags
// when the count has reached MEM_TIMEOUT-1.
module hazard_ctrl_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = $clog2(MEM_TIMEOUT);

    logic [W-1:0] count;

    assign expired = (count == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage stall/flush for MEM waits, mul/div,
// redirects and load-use bubbles, plus MEM watchdog and stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 1024,
    parameter int unsigned CNT_W       = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 idu_valid,
    input  logic [REG_IDX_W-1:0] idu_index_rs1,
    input  logic                 idu_use_rs1,
    input  logic [REG_IDX_W-1:0] idu_index_rs2,
    input  logic                 idu_use_rs2,
    input  logic                 exu_valid,
    input  logic [REG_IDX_W-1:0] exu_index_rd,
    input  logic                 exu_wb_en,
    input  logic                 exu_is_load,
    input  logic                 exu_md_start,
    input  logic                 md_done,
    input  logic                 exu_redirect,
    input  logic                 mmu_req,
    input  logic                 mmu_ack,
    output logic                 pc_stall,
    output logic                 ifid_stall,
    output logic                 idex_stall,
    output logic                 exmm_stall,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmm_flush,
    output logic                 mmwb_flush,
    output logic [1:0]           ctrl_state,
    output logic                 mem_timeout_err,
    output logic [CNT_W-1:0]     stall_cycles
);

    ctrl_state_e state;
    pipe_ctrl_t  ctrl;
    logic        mem_cond;
    logic        md_cond;
    logic        load_use;
    logic        expired;

    assign mem_cond = mmu_req && !mmu_ack;
    assign md_cond  = ((state == ST_RUN) && exu_md_start) ||
                      ((state == ST_MD_WAIT) && !md_done);
    assign load_use = exu_valid && exu_is_load && exu_wb_en && idu_valid &&
                      (src_hit(exu_index_rd, idu_use_rs1, idu_index_rs1) ||
                       src_hit(exu_index_rd, idu_use_rs2, idu_index_rs2));

    // Redirect sits above load-use: the ID instruction is wrong-path anyway.
    always_comb begin
        ctrl = CTRL_NONE;
        if (rst) begin
            ctrl = CTRL_NONE;
        end else if ((state == ST_ERR) || mem_cond) begin
            ctrl = CTRL_MEM;
        end else if (md_cond) begin
            ctrl = CTRL_MD;
        end else if (exu_redirect) begin
            ctrl = CTRL_REDIR;
        end else if (load_use) begin
            ctrl = CTRL_LDUSE;
        end
    end

    assign pc_stall   = ctrl.pc_stall;
    assign ifid_stall = ctrl.ifid_stall;
    assign idex_stall = ctrl.idex_stall;
    assign exmm_stall = ctrl.exmm_stall;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign exmm_flush = ctrl.exmm_flush;
    assign mmwb_flush = ctrl.mmwb_flush;
    assign ctrl_state = state;

    hazard_ctrl_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != ST_MEM_WAIT),
        .en      (state == ST_MEM_WAIT),
        .expired (expired)
    );

    // A MEM stall inside MD_WAIT holds in place; md_done still releases to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_RUN;
            mem_timeout_err <= 1'b0;
            stall_cycles    <= '0;
        end else begin
            if (ctrl.pc_stall) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            case (state)
                ST_RUN: begin
                    if (mem_cond) begin
                        state <= ST_MEM_WAIT;
                    end else if (exu_md_start) begin
                        state <= ST_MD_WAIT;
                    end
                end
                ST_MD_WAIT: begin
                    if (md_done) begin
                        state <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_cond) begin
                        state <= ST_RUN;
                    end else if (expired) begin
                        state           <= ST_ERR;
                        mem_timeout_err <= 1'b1;
                    end
                end
                ST_ERR: begin
                    state <= ST_ERR;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a rule-level model.
module tb_hazard_ctrl;

    localparam int unsigned TO = 8;
    localparam int unsigned CW = 8;

    localparam logic [7:0] E_NONE  = 8'b0000_0000;
    localparam logic [7:0] E_MEM   = 8'b1111_0001;
    localparam logic [7:0] E_MD    = 8'b1110_0010;
    localparam logic [7:0] E_REDIR = 8'b0000_1100;
    localparam logic [7:0] E_LU    = 8'b1100_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          idu_valid, idu_use_rs1, idu_use_rs2;
    logic [4:0]    idu_index_rs1, idu_index_rs2, exu_index_rd;
    logic          exu_valid, exu_wb_en, exu_is_load, exu_md_start, md_done;
    logic          exu_redirect, mmu_req, mmu_ack;
    logic          pc_stall, ifid_stall, idex_stall, exmm_stall;
    logic          ifid_flush, idex_flush, exmm_flush, mmwb_flush;
    logic [1:0]    ctrl_state;
    logic          mem_timeout_err;
    logic [CW-1:0] stall_cycles;
    logic [7:0]    sf;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .idu_valid(idu_valid), .idu_index_rs1(idu_index_rs1), .idu_use_rs1(idu_use_rs1),
        .idu_index_rs2(idu_index_rs2), .idu_use_rs2(idu_use_rs2),
        .exu_valid(exu_valid), .exu_index_rd(exu_index_rd), .exu_wb_en(exu_wb_en),
        .exu_is_load(exu_is_load), .exu_md_start(exu_md_start), .md_done(md_done),
        .exu_redirect(exu_redirect), .mmu_req(mmu_req), .mmu_ack(mmu_ack),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmm_stall(exmm_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmm_flush(exmm_flush), .mmwb_flush(mmwb_flush), .ctrl_state(ctrl_state),
        .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
    );

    assign sf = {pc_stall, ifid_stall, idex_stall, exmm_stall,
                 ifid_flush, idex_flush, exmm_flush, mmwb_flush};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 run, 1 mul/div wait, 2 mem wait, 3 error.
    int mode = 0;
    int wd   = 0;
    int mcnt = 0;
    bit merr = 1'b0;

    function automatic logic [7:0] expect_ctrl();
        bit mem_hold, md_busy, dep;
        mem_hold = mmu_req && !mmu_ack;
        md_busy  = (mode == 0 && exu_md_start) || (mode == 1 && !md_done);
        dep = exu_valid && exu_is_load && exu_wb_en && idu_valid && exu_index_rd != 0 &&
              ((idu_use_rs1 && exu_index_rd == idu_index_rs1) ||
               (idu_use_rs2 && exu_index_rd == idu_index_rs2));
        if (rst)                       return E_NONE;
        if (mode == 3 || mem_hold)     return E_MEM;
        if (md_busy)                   return E_MD;
        if (exu_redirect)              return E_REDIR;
        if (dep)                       return E_LU;
        return E_NONE;
    endfunction

    always @(negedge clk) begin
        logic [7:0] e;
        bit         mem_hold;
        e = expect_ctrl();
        mem_hold = mmu_req && !mmu_ack;
        check("ctrl", sf, e);
        check("ctrl_state", ctrl_state, mode);
        check("mem_timeout_err", mem_timeout_err, merr);
        check("stall_cycles", stall_cycles, mcnt);
        if (rst) begin
            mode = 0; wd = 0; mcnt = 0; merr = 1'b0;
        end else begin
            if (e[7]) mcnt = (mcnt + 1) % (1 << CW);
            case (mode)
                0: if (mem_hold) begin mode = 2; wd = 0; end
                   else if (exu_md_start) mode = 1;
                1: if (md_done) mode = 0;
                2: if (!mem_hold) begin mode = 0; wd = 0; end
                   else if (wd == TO - 1) begin mode = 3; merr = 1'b1; end
                   else wd++;
                default: mode = 3;
            endcase
        end
    end

    task automatic idle();
        rst = 1'b0; idu_valid = 1'b0; idu_use_rs1 = 1'b0; idu_use_rs2 = 1'b0;
        idu_index_rs1 = '0; idu_index_rs2 = '0; exu_index_rd = '0;
        exu_valid = 1'b0; exu_wb_en = 1'b0; exu_is_load = 1'b0; exu_md_start = 1'b0;
        md_done = 1'b0; exu_redirect = 1'b0; mmu_req = 1'b0; mmu_ack = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic setup_load_use();
        exu_valid = 1'b1; exu_is_load = 1'b1; exu_wb_en = 1'b1; exu_index_rd = 5'd5;
        idu_valid = 1'b1; idu_use_rs1 = 1'b1; idu_index_rs1 = 5'd5;
        idu_use_rs2 = 1'b1; idu_index_rs2 = 5'd7;
    endtask

    int ack_thr;

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) begin sample(); check("reset_outputs", sf, E_NONE); advance(); end
        rst = 1'b0;
        sample();
        check("reset_state", ctrl_state, 0);
        check("reset_cnt", stall_cycles, 0);
        check("reset_err", mem_timeout_err, 0);
        advance();

        // load-use bubble, then release
        setup_load_use();
        sample(); check("t1_bubble", sf, E_LU); advance();
        exu_valid = 1'b0;
        sample(); check("t1_release", sf, E_NONE); check("t1_cnt", stall_cycles, 1); advance();

        // x0 and unused sources never stall; rs2 match does
        setup_load_use(); exu_index_rd = 5'd0; idu_index_rs1 = 5'd0;
        sample(); check("t2_x0", sf, E_NONE); advance();
        setup_load_use(); idu_use_rs1 = 1'b0;
        sample(); check("t2_unused", sf, E_NONE); advance();
        idu_index_rs2 = 5'd5;
        sample(); check("t2_rs2", sf, E_LU); advance();
        idle();
        sample(); check("t2_cnt", stall_cycles, 2); advance();

        // mul/div: start at 0, done at 5
        exu_md_start = 1'b1;
        sample(); check("t3_c0", sf, E_MD); check("t3_s0", ctrl_state, 0); advance();
        exu_md_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sample(); check("t3_stall", sf, E_MD); check("t3_wait", ctrl_state, 1); advance();
        end
        md_done = 1'b1;
        sample(); check("t3_done", sf, E_NONE); check("t3_s5", ctrl_state, 1); advance();
        md_done = 1'b0;
        sample(); check("t3_s6", ctrl_state, 0); check("t3_cnt", stall_cycles, 7); advance();

        // MEM wait, ack at cycle 3
        mmu_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample(); check("t4_stall", sf, E_MEM); check("t4_state", ctrl_state, (i == 0) ? 0 : 2);
            advance();
        end
        mmu_ack = 1'b1;
        sample(); check("t4_ack", sf, E_NONE); advance();
        idle();
        sample(); check("t4_run", ctrl_state, 0); check("t4_cnt", stall_cycles, 10); advance();

        // redirect beats load-use; redirect masked by MEM, applies on ack
        setup_load_use(); exu_redirect = 1'b1;
        sample(); check("t5_redir_lu", sf, E_REDIR); advance();
        idle(); exu_redirect = 1'b1; mmu_req = 1'b1;
        repeat (2) begin sample(); check("t5_masked", sf, E_MEM); advance(); end
        mmu_ack = 1'b1;
        sample(); check("t5_on_ack", sf, E_REDIR); advance();

        // same-cycle req+ack: no stall, stays RUN
        idle(); mmu_req = 1'b1; mmu_ack = 1'b1;
        sample(); check("req_ack_zero", sf, E_NONE); advance();
        idle();
        sample(); check("req_ack_run", ctrl_state, 0); advance();

        // MEM stall while in MD_WAIT keeps MD_WAIT
        exu_md_start = 1'b1;
        sample(); check("mdmem_c0", sf, E_MD); advance();
        exu_md_start = 1'b0; mmu_req = 1'b1;
        sample(); check("mdmem_c1", sf, E_MEM); check("mdmem_s1", ctrl_state, 1); advance();
        mmu_req = 1'b0; md_done = 1'b1;
        sample(); check("mdmem_c2", sf, E_NONE); advance();
        idle();
        sample(); check("mdmem_run", ctrl_state, 0); check("mdmem_cnt", stall_cycles, 14); advance();

        // watchdog expiry, sticky error, reset recovery
        mmu_req = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            sample(); check("t6_wait", sf, E_MEM); advance();
        end
        sample(); check("t6_err_state", ctrl_state, 3); check("t6_err", mem_timeout_err, 1); advance();
        mmu_req = 1'b0;
        repeat (3) begin
            sample(); check("t6_held", sf, E_MEM); check("t6_sticky", mem_timeout_err, 1); advance();
        end
        rst = 1'b1;
        sample(); check("t6_rst_out", sf, E_NONE); advance();
        rst = 1'b0;
        sample();
        check("t6_rec_state", ctrl_state, 0);
        check("t6_rec_cnt", stall_cycles, 0);
        check("t6_rec_err", mem_timeout_err, 0);
        check("t6_rec_out", sf, E_NONE);
        advance();

        // randomized traffic
        ack_thr = 4;
        for (int n = 0; n < 4000; n++) begin
            if (n % 256 == 0) ack_thr = $urandom_range(1, 5);
            rst           = (mode == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
            idu_valid     = $urandom_range(0, 3) != 0;
            idu_use_rs1   = $urandom_range(0, 1) != 0;
            idu_use_rs2   = $urandom_range(0, 1) != 0;
            idu_index_rs1 = 5'($urandom_range(0, 3));
            idu_index_rs2 = 5'($urandom_range(0, 3));
            exu_index_rd  = 5'($urandom_range(0, 3));
            exu_valid     = $urandom_range(0, 3) != 0;
            exu_wb_en     = $urandom_range(0, 3) != 0;
            exu_is_load   = $urandom_range(0, 1) != 0;
            exu_md_start  = $urandom_range(0, 7) == 0;
            md_done       = $urandom_range(0, 2) == 0;
            exu_redirect  = $urandom_range(0, 7) == 0;
            mmu_req       = $urandom_range(0, 3) == 0;
            mmu_ack       = mmu_req && ($urandom_range(0, 7) < ack_thr);
            sample();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
